// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared fetch-state encoding, default reset PC and response codes.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_RESP,
        S_OUT,
        S_COMMIT
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
// Ports: clk/rst_n (sync active-low); imem_ar*/imem_r* read channels to instruction
// memory; out_* handoff (valid/ready, inst, pc, fault) to decode; commit_valid/commit_pc
// next-PC from the retiring instruction; fetch_cnt counts completed handoffs.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_arvalid,
    input  logic        imem_arready,
    output logic [31:0] imem_araddr,
    input  logic        imem_rvalid,
    output logic        imem_rready,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    output logic [31:0] fetch_cnt
);

    fetch_state_t state, next;
    logic [31:0]  pc;
    logic         misaligned;

    assign misaligned   = pc[1:0] != 2'b00;
    // Handshake outputs are pure decodes of registered state/pc, never of inputs.
    assign imem_arvalid = state == S_REQ && !misaligned;
    assign imem_araddr  = pc;
    assign imem_rready  = state == S_RESP;
    assign out_valid    = state == S_OUT;
    // pc only moves in S_COMMIT, so it doubles as the pc of the fetch being handed off.
    assign out_pc       = pc;

    always_comb begin
        next = state;
        case (state)
            S_REQ:    next = misaligned ? S_OUT : (imem_arready ? S_RESP : S_REQ);
            S_RESP:   next = imem_rvalid ? S_OUT : S_RESP;
            S_OUT:    next = out_ready ? S_COMMIT : S_OUT;
            S_COMMIT: next = commit_valid ? S_REQ : S_COMMIT;
            default:  next = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            out_inst  <= '0;
            out_fault <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state <= next;
            if (state == S_REQ && misaligned) begin
                out_inst  <= '0;
                out_fault <= 1'b1;
            end
            if (state == S_RESP && imem_rvalid) begin
                out_inst  <= imem_rresp == RESP_OKAY ? imem_rdata : 32'h0;
                out_fault <= imem_rresp != RESP_OKAY;
            end
            if (state == S_OUT && out_ready)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (state == S_COMMIT && commit_valid)
                pc <= commit_pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: table-driven fetch transactions plus directed stall and reset sequences.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_arvalid, imem_arready;
    logic [31:0] imem_araddr;
    logic        imem_rvalid, imem_rready;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_pc;
    logic        out_fault;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_cnt = 0;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_arvalid(imem_arvalid), .imem_arready(imem_arready), .imem_araddr(imem_araddr),
        .imem_rvalid(imem_rvalid), .imem_rready(imem_rready), .imem_rdata(imem_rdata),
        .imem_rresp(imem_rresp),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_fault(out_fault),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        int          ar_wait;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] inst;
        logic        fault;
        logic [31:0] next_pc;
        int          cycles;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int t0;
        t0 = cyc;
        if (v.pc[1:0] == 2'b00) begin
            chk("arvalid", {31'b0, imem_arvalid}, 32'd1);
            chk("araddr", imem_araddr, v.pc);
            imem_arready = 1'b0;
            for (int i = 0; i < v.ar_wait; i++) begin
                tick();
                chk("arvalid_hold", {31'b0, imem_arvalid}, 32'd1);
                chk("araddr_hold", imem_araddr, v.pc);
            end
            imem_arready = 1'b1;
            tick();
            imem_arready = 1'b0;
            chk("rready", {31'b0, imem_rready}, 32'd1);
            imem_rvalid = 1'b1;
            imem_rdata  = v.rdata;
            imem_rresp  = v.rresp;
            tick();
            imem_rvalid = 1'b0;
        end else begin
            chk("arvalid_misaligned", {31'b0, imem_arvalid}, 32'd0);
            tick();
        end
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("out_inst", out_inst, v.inst);
        chk("out_fault", {31'b0, out_fault}, {31'b0, v.fault});
        chk("out_pc", out_pc, v.pc);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        chk("commit_idle", {29'b0, imem_arvalid, imem_rready, out_valid}, 32'd0);
        chk("fetch_cnt", fetch_cnt, exp_cnt);
        commit_valid = 1'b1;
        commit_pc    = v.next_pc;
        tick();
        commit_valid = 1'b0;
        chk("latency", cyc - t0, v.cycles);
    endtask

    initial begin
        tbl[0] = '{32'h8000_0000, 0, 32'h0000_0093, 2'b00, 32'h0000_0093, 1'b0, 32'h8000_0004, 4};
        tbl[1] = '{32'h8000_0004, 3, 32'h0010_0113, 2'b00, 32'h0010_0113, 1'b0, 32'h8000_0008, 7};
        tbl[2] = '{32'h8000_0008, 0, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 1'b1, 32'h8000_0100, 4};
        tbl[3] = '{32'h8000_0100, 1, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0, 32'h8000_0102, 5};
        tbl[4] = '{32'h8000_0102, 0, 32'h0,         2'b00, 32'h0000_0000, 1'b1, 32'h8000_0200, 3};
        tbl[5] = '{32'h8000_0200, 0, 32'h5555_AAAA, 2'b01, 32'h0000_0000, 1'b1, 32'h8000_0204, 4};

        rst_n = 1'b0;
        imem_arready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_rresp = '0;
        out_ready = 1'b0; commit_valid = 1'b0; commit_pc = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("rst_araddr", imem_araddr, 32'h8000_0000);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Stray rvalid in S_REQ, then out_ready stalled with a commit pulse and stray rvalid in S_OUT.
        imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_rvalid = 1'b0;
        chk("stray_r_arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("stray_r_rready", {31'b0, imem_rready}, 32'd0);
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0013; imem_rresp = 2'b00;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            commit_valid = (i == 2);
            commit_pc    = 32'h8000_0F00;
            imem_rvalid  = (i == 3);
            imem_rdata   = 32'h0BAD_0BAD;
            tick();
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_inst", out_inst, 32'hCAFE_0013);
            chk("stall_pc", out_pc, 32'h8000_0204);
            chk("stall_fault", {31'b0, out_fault}, 32'd0);
        end
        commit_valid = 1'b0; imem_rvalid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        chk("stall_cnt", fetch_cnt, exp_cnt);
        commit_valid = 1'b1; commit_pc = 32'h8000_0208;
        tick();
        commit_valid = 1'b0;
        chk("stall_next_araddr", imem_araddr, 32'h8000_0208);

        // Reset in S_RESP with a stale rvalid arriving just after.
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        chk("pre_rst_rready", {31'b0, imem_rready}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777;
        chk("mid_rst_araddr", imem_araddr, 32'h8000_0000);
        chk("mid_rst_inst", out_inst, 32'd0);
        chk("mid_rst_cnt", fetch_cnt, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        chk("stale_r_arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("stale_r_rready", {31'b0, imem_rready}, 32'd0);
        chk("stale_r_inst", out_inst, 32'd0);
        chk("stale_r_araddr", imem_araddr, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
